line_data_memory: RTL and testbench

- Off-chip data memory model that sits directly downstream of the L1 dcache.
- Serves 256-bit cache-line reads and writes through the dcache's enable/write/ack memory interface.
- Fixed, parameterised access latency stands in for DRAM timing, so dcache miss, refill and write-back stalls show up at the CPU pipeline.
- Instantiated in the testbench alongside the CPU; contents are preloaded and dumped by the bench.

---
 rtl/line_data_memory_pkg.sv | 17 +
 rtl/line_data_memory_line_ram.sv | 44 ++++
 rtl/line_data_memory.sv | 108 ++++++++++
 tb/tb_line_data_memory.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/line_data_memory_pkg.sv
// rtl/line_data_memory_pkg.sv - shared constants and types for the line data memory model
package line_data_memory_pkg;

  // Cache-line width; matches the dcache line size.
  localparam int LINE_W = 256;

  // Transaction FSM. ACK is the cycle that launches the commit and the ack pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Latency counter; wide enough for LATENCY up to 255.
  typedef logic [7:0] lat_cnt_t;

endpackage

// File: rtl/line_data_memory_line_ram.sv
// rtl/line_data_memory_line_ram.sv - single-port line storage with registered read data
module line_ram
  import line_data_memory_pkg::*;
#(
  parameter int LINE_W = line_data_memory_pkg::LINE_W,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;

  // Storage array: never reset, so preloaded contents survive reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Read register: a write returns the written line, a read the stored line; held between accesses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= we_i ? wdata_i : mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

  // Preload hook for the bench: schedules a line write outside the functional port.
  task automatic preload_line(input logic [IDX_W-1:0] idx, input logic [LINE_W-1:0] line);
    mem_q[idx] <= line;
  endtask

endmodule

// File: rtl/line_data_memory.sv
// rtl/line_data_memory.sv - fixed-latency cache-line memory behind the dcache
module line_data_memory
  import line_data_memory_pkg::*;
#(
  parameter int LINE_W   = line_data_memory_pkg::LINE_W,
  parameter int DEPTH    = 512,
  parameter int LATENCY  = 10,
  parameter int OFFSET_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int       IDX_W    = $clog2(DEPTH);
  localparam lat_cnt_t LAT_LOAD = lat_cnt_t'(LATENCY - 1);

  state_e            state_q, state_d;
  lat_cnt_t          cnt_q, cnt_d;
  logic [IDX_W-1:0]  req_idx_q, req_idx_d;
  logic              req_write_q, req_write_d;
  logic [LINE_W-1:0] req_data_q, req_data_d;
  logic              ack_q;
  logic              commit;

  // Offset bits and upper bits above the index do not select anything; wrap is modulo DEPTH.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};

  // Next-state: accept in IDLE, count down in WAIT, ACK lasts one cycle.
  // The ACK state precedes the visible ack pulse by one edge, so a request accepted
  // at E0 acks at E0+LATENCY and the next one can be accepted at E0+LATENCY+1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_idx_d   = req_idx_q;
    req_write_d = req_write_q;
    req_data_d  = req_data_q;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          req_idx_d   = addr_i[OFFSET_W +: IDX_W];
          req_write_d = write_i;
          req_data_d  = data_i;
          cnt_d       = LAT_LOAD;
          state_d     = (LATENCY == 1) ? ACK : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - lat_cnt_t'(1);
        if (cnt_q == lat_cnt_t'(1)) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and the ack pulse; reset abandons any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_q == ACK);
    end
  end

  // Request registers: only change on acceptance, so mid-transaction input changes are ignored.
  always_ff @(posedge clk_i) begin
    req_idx_q   <= req_idx_d;
    req_write_q <= req_write_d;
    req_data_q  <= req_data_d;
  end

  // Storage commit happens on the same edge that raises ack; reset on that edge blocks it.
  assign commit = (state_q == ACK) && !rst_i;

  line_ram #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (commit),
    .we_i    (req_write_q),
    .idx_i   (req_idx_q),
    .wdata_i (req_data_q),
    .rdata_o (data_o)
  );

  assign ack_o = ack_q;

endmodule

// File: tb/tb_line_data_memory.sv
// tb/tb_line_data_memory.sv - self-checking bench for line_data_memory
module tb_line_data_memory;

  localparam int LW    = 256;
  localparam int DEP   = 512;
  localparam int LAT   = 10;
  localparam int OFS_W = 5;

  logic          clk;
  logic          rst;
  logic [31:0]   addr;
  logic [LW-1:0] wdata;
  logic          enable;
  logic          write;
  logic          ack;
  logic [LW-1:0] rdata;

  int checks = 0;
  int errors = 0;

  logic [LW-1:0] model [DEP];

  line_data_memory #(
    .LINE_W   (LW),
    .DEPTH    (DEP),
    .LATENCY  (LAT),
    .OFFSET_W (OFS_W)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .addr_i   (addr),
    .data_i   (wdata),
    .enable_i (enable),
    .write_i  (write),
    .ack_o    (ack),
    .data_o   (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32) % DEP);
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request through the enable/ack handshake; lat = edges from acceptance to ack (-1 on timeout).
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [LW-1:0] d,
                         input bit disturb, output int lat, output logic [LW-1:0] got,
                         output bit one_cycle);
    lat = -1;
    got = '0;
    one_cycle = 1'b0;
    @(negedge clk);
    addr = a; write = w; wdata = d; enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    if (disturb) begin
      addr  = a ^ 32'h0000_01E0;
      write = ~w;
      wdata = ~d;
    end
    for (int k = 2; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = k - 1;
        got = rdata;
        break;
      end
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
      one_cycle = !ack;
    end
    write = 1'b0;
  endtask

  // Executes a transaction against the model and checks latency, pulse width and data.
  task automatic txn_checked(input string tag, input logic [31:0] a, input logic w,
                             input logic [LW-1:0] d, input bit disturb);
    int            lat;
    logic [LW-1:0] got;
    logic [LW-1:0] exp;
    bit            one;
    exp = w ? d : model[idx_of(a)];
    if (w) model[idx_of(a)] = d;
    run_txn(a, w, d, disturb, lat, got, one);
    check({tag, "_lat"}, LW'(lat), LW'(LAT));
    check({tag, "_onecyc"}, LW'(one), LW'(1));
    check({tag, "_data"}, got, exp);
  endtask

  initial begin
    int            acks;
    int            alt;
    logic [31:0]   a;
    logic [LW-1:0] d;

    rst = 1'b1; enable = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < DEP; i++) begin
      d = (i == 3) ? {8{32'hDEADBEEF}} : rand_line();
      model[i] = d;
      dut.u_ram.preload_line(9'(i), d);
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", LW'(ack), LW'(0));
    check("reset_data", rdata, '0);
    @(negedge clk);
    rst = 1'b0;

    // 1: read preloaded line 3
    txn_checked("t1_read3", 32'h0000_0060, 1'b0, '0, 1'b0);

    // 2: write line 1, read back, neighbours untouched
    txn_checked("t2_write", 32'h0000_0020, 1'b1, {8{32'h12345678}}, 1'b0);
    txn_checked("t2_readback", 32'h0000_0020, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++)
      if (i != 1) check($sformatf("t2_line%0d", i), dut.u_ram.mem_q[i], model[i]);

    // 3: enable held high -> accepts at n*(LAT+1), acks LAT later
    a = 32'h0000_00A0;
    @(negedge clk);
    addr = a; write = 1'b0; enable = 1'b1;
    acks = 0;
    for (int k = 0; k <= 3 * LAT + 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("t3_ack_e%0d", k), LW'(ack), LW'((k % (LAT + 1)) == LAT));
      if (ack) begin
        acks++;
        check($sformatf("t3_data_e%0d", k), rdata, model[idx_of(a)]);
      end
    end
    enable = 1'b0;
    check("t3_ack_count", LW'(acks), LW'(3));

    // 4: reset during a write to line 7 abandons it
    d = rand_line();
    @(negedge clk);
    addr = 32'h0000_00E0; write = 1'b1; wdata = d; enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0; write = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    check("t4_no_ack", LW'(acks), LW'(0));
    check("t4_data_zero", rdata, '0);
    check("t4_line7", dut.u_ram.mem_q[7], model[7]);
    txn_checked("t4_fresh_read", 32'h0000_00A0, 1'b0, '0, 1'b0);

    // 5: upper index bits wrap modulo DEPTH
    txn_checked("t5_wrap", 32'h0000_4060, 1'b0, '0, 1'b0);

    // 6: inputs changed and enable dropped during WAIT
    a = 32'h0000_0120;
    alt = idx_of(a ^ 32'h0000_01E0);
    txn_checked("t6_latched", a, 1'b0, '0, 1'b1);
    check("t6_alt_line", dut.u_ram.mem_q[alt], model[alt]);

    // random traffic, including wrapped and offset-bearing addresses
    for (int n = 0; n < 12; n++) begin
      a = $urandom;
      if (n % 3 == 2) a = {$urandom_range(0, 65535), 16'h0} | 32'(idx_of(a) % 8) << OFS_W;
      txn_checked($sformatf("rnd%0d", n), a, 1'($urandom_range(0, 1)), rand_line(), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
